// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronise, debounce and stretch the up/down/ok push-buttons
// Optional KEY_ACTIVE_LOW_EN: raw buttons read 0 when pressed.
module key_conditioner #(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic btn_ok_raw,
   output logic up,
   output logic down,
   output logic ok
);

   localparam int UP = 0;
   localparam int DN = 1;
   localparam int OK = 2;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

   logic [2:0] raw_in;
   logic [2:0] s0, s1, st;
   logic [2:0] press, cut, active;
   logic [CNT_W-1:0] db_cnt   [3];
   logic [CNT_W-1:0] hold_cnt [3];

`ifdef KEY_ACTIVE_LOW_EN
   assign raw_in = ~{btn_ok_raw, btn_down_raw, btn_up_raw};
`else
   assign raw_in = {btn_ok_raw, btn_down_raw, btn_up_raw};
`endif

   always_comb begin
      press  = '0;
      active = '0;
      for (int i = 0; i < 3; i++) begin
         press[i]  = ~st[i] & s1[i] & (db_cnt[i] == DB_LAST);
         active[i] = st[i] | (hold_cnt[i] != '0);
      end
      // a fresh up press cancels a pending down stretch and vice versa
      cut = {1'b0, press[UP], press[DN]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0   <= '0;
         s1   <= '0;
         st   <= '0;
         up   <= 1'b0;
         down <= 1'b0;
         ok   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         s0 <= raw_in;
         s1 <= s0;
         for (int i = 0; i < 3; i++) begin
            if (s1[i] == st[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               st[i]     <= s1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end

            if (press[i]) begin
               hold_cnt[i] <= HOLD_LOAD;
            end else if (cut[i]) begin
               hold_cnt[i] <= '0;
            end else if (hold_cnt[i] != '0) begin
               hold_cnt[i] <= hold_cnt[i] - CNT_W'(1);
            end
         end
         // both directions held at once is ambiguous, so neither is reported
         up   <= active[UP] & ~(st[UP] & st[DN]);
         down <= active[DN] & ~(st[UP] & st[DN]);
         ok   <= active[OK];
      end
   end

endmodule
